uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the single write port of the AXI FIFO UART transmit FIFO among NUM_REQ byte-stream requesters.
- Example requesters: AXI4-Lite register path, DMA path, debug path.
- Grants are packet-atomic: a granted requester keeps the FIFO port until it sends a beat with last, or until the MAX_PKT beat limit is reached.
- Sits between the requesters and the TX FIFO write interface in the UART core.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- MAX_PKT, 64, maximum beats per grant before forced release (1..65535).
- GW, $clog2(NUM_REQ), width of grant_id (derived localparam, not user-set).

Ports:
- ACLK  in  1  clock.
- ARESETN  in  1  synchronous active-low reset.
- enable  in  1  when low, no new grant is issued; an open packet still completes.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  per-requester last-byte-of-packet flag.
- req_ready  out  NUM_REQ  per-requester ready.
- fifo_full  in  1  TX FIFO full.
- fifo_wr_en  out  1  TX FIFO write strobe.
- fifo_wr_data  out  8  TX FIFO write byte.
- busy  out  1  high while a grant is held (state XFER).
- grant_id  out  GW  index of the current or most recent grantee.
- pkt_done  out  1  one-cycle pulse when a packet ends with last.
- err_len  out  1  one-cycle pulse when a packet is force-ended at MAX_PKT.

Behaviour:
- Reset values (ARESETN low at a rising edge):
  - state=IDLE, busy=0, grant_id=NUM_REQ-1, beat_cnt=0.
  - pkt_done=0, err_len=0, req_ready=0, fifo_wr_en=0, fifo_wr_data=0.
  - Reset mid-packet aborts the grant with no pulse. The requester's remaining bytes are arbitrated as a new packet later.
- States:
  - IDLE: no grant.
  - XFER: grant held.
- IDLE -> XFER:
  - Condition: enable=1 and |req_valid.
  - Winner is the first i with req_valid[i]=1, searching (grant_id+1) mod NUM_REQ upward with wrap.
  - At the clock edge: grant_id<=winner, busy<=1, beat_cnt<=0.
  - Arbitration latency is 1 cycle. No transfer happens in the IDLE cycle.
- XFER, combinational, with g=grant_id:
  - req_ready[g]=~fifo_full; all other req_ready bits are 0.
  - fifo_wr_en=req_valid[g] & ~fifo_full.
  - fifo_wr_data=req_data[g] (0 when not in XFER).
  - A beat occurs when fifo_wr_en=1.
  - Requester rule: valid, data and last are held until the beat. Valid must not depend on ready.
- XFER, on each beat:
  - If req_last[g]: pkt_done<=1 next cycle, go to IDLE.
  - Else if beat_cnt==MAX_PKT-1: err_len<=1 next cycle, go to IDLE. The requester's next byte starts a new arbitration.
  - Else: beat_cnt<=beat_cnt+1.
  - beat_cnt is 16 bits and never wraps, because release happens at MAX_PKT.
- XFER with no beat (valid low or fifo_full): hold grant indefinitely, no timeout.
- enable falling during XFER has no effect until the packet ends; then stay in IDLE while enable=0.
- grant_id holds its value in IDLE and is the round-robin pointer. The previous grantee therefore has lowest priority next round.
- Back-to-back packets always pass through one IDLE cycle. Peak throughput is N beats per N+1 cycles.
- Last and MAX_PKT on the same beat: last wins, so pkt_done=1 and err_len=0.
- fifo_full rising in the same cycle as valid: no beat, byte held, no state change.

Test Plan:
- Reset then a single requester:
  - Stimulus: req 2 sends 3 bytes 0xA1,0xA2,0xA3 with last on 0xA3, fifo_full=0.
  - Required: grant_id=2 one cycle after valid; fifo_wr_en high for 3 consecutive cycles with those bytes; pkt_done pulse; busy=0.
- All four requesters valid continuously, each with 2-byte packets, from reset:
  - Required: grant order 0,1,2,3,0; each grant gives exactly 2 writes; 1 idle cycle between packets.
- fifo_full asserted for 5 cycles mid-packet of req 1:
  - Required: req_ready[1]=0 and fifo_wr_en=0 during those cycles; data byte held; transfer resumes with no loss or duplication; grant unchanged.
- MAX_PKT=4, req 0 streams 6 bytes with no last:
  - Required: 4 writes then err_len pulse; re-arbitration; remaining 2 bytes sent under a new grant.
- enable dropped after first byte of a 3-byte packet from req 3, req 0 also valid:
  - Required: packet completes (3 writes, pkt_done); no grant to req 0 until enable=1.
- ARESETN low for 1 cycle mid-packet:
  - Required: outputs return to reset values next cycle; no pkt_done or err_len; next grant starts the search at req 0.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-atomic arbiter sharing the UART TX FIFO write port
// among NUM_REQ byte-stream requesters.
module uart_tx_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int MAX_PKT = 64
) (
    input  logic                         ACLK,
    input  logic                         ARESETN,
    input  logic                         enable,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [8*NUM_REQ-1:0]         req_data,
    input  logic [NUM_REQ-1:0]           req_last,
    output logic [NUM_REQ-1:0]           req_ready,
    input  logic                         fifo_full,
    output logic                         fifo_wr_en,
    output logic [7:0]                   fifo_wr_data,
    output logic                         busy,
    output logic [$clog2(NUM_REQ)-1:0]   grant_id,
    output logic                         pkt_done,
    output logic                         err_len
);

    localparam int GW = $clog2(NUM_REQ);

    typedef enum logic {
        IDLE = 1'b0,
        XFER = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [GW-1:0]   grant_q, grant_d;
    logic [15:0]     beat_cnt_q, beat_cnt_d;
    logic            pkt_done_q, pkt_done_d;
    logic            err_len_q, err_len_d;
    logic [GW-1:0]   winner;
    logic            found;
    logic [GW-1:0]   cand;

    // Round-robin search starts just after the most recent grantee.
    always_comb begin
        winner = grant_q;
        found  = 1'b0;
        cand   = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = GW'((int'(grant_q) + k) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        beat_cnt_d   = beat_cnt_q;
        pkt_done_d   = 1'b0;
        err_len_d    = 1'b0;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_wr_data = 8'h00;
        case (state_q)
            IDLE: begin
                if (enable && found) begin
                    state_d    = XFER;
                    grant_d    = winner;
                    beat_cnt_d = 16'd0;
                end
            end
            XFER: begin
                req_ready[grant_q] = ~fifo_full;
                fifo_wr_en         = req_valid[grant_q] & ~fifo_full;
                fifo_wr_data       = req_data[8*int'(grant_q) +: 8];
                // last takes precedence over the length limit on the same beat
                if (fifo_wr_en) begin
                    if (req_last[grant_q]) begin
                        pkt_done_d = 1'b1;
                        state_d    = IDLE;
                    end else if (beat_cnt_q == 16'(MAX_PKT - 1)) begin
                        err_len_d = 1'b1;
                        state_d   = IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 16'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            state_q    <= IDLE;
            grant_q    <= GW'(NUM_REQ - 1);
            beat_cnt_q <= 16'd0;
            pkt_done_q <= 1'b0;
            err_len_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            pkt_done_q <= pkt_done_d;
            err_len_q  <= err_len_d;
        end
    end

    assign busy     = (state_q == XFER);
    assign grant_id = grant_q;
    assign pkt_done = pkt_done_q;
    assign err_len  = err_len_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with NUM_REQ=4 and MAX_PKT=4.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ = 4;
    localparam int MAX_PKT = 4;

    logic                 ACLK = 1'b0;
    logic                 ARESETN;
    logic                 enable;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic                 fifo_full;
    logic                 fifo_wr_en;
    logic [7:0]           fifo_wr_data;
    logic                 busy;
    logic [1:0]           grant_id;
    logic                 pkt_done;
    logic                 err_len;

    int n_cmp = 0;
    int n_err = 0;

    uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .MAX_PKT(MAX_PKT)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN), .enable(enable),
        .req_valid(req_valid), .req_data(req_data), .req_last(req_last),
        .req_ready(req_ready), .fifo_full(fifo_full), .fifo_wr_en(fifo_wr_en),
        .fifo_wr_data(fifo_wr_data), .busy(busy), .grant_id(grant_id),
        .pkt_done(pkt_done), .err_len(err_len)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge ACLK);
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] d, input logic l);
        req_valid[i]       = v;
        req_data[8*i +: 8] = d;
        req_last[i]        = l;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_gid"}, 32'(grant_id), 32'd3);
        chk({tag, "_pkt_done"}, 32'(pkt_done), 32'd0);
        chk({tag, "_err_len"}, 32'(err_len), 32'd0);
        chk({tag, "_wr_en"}, 32'(fifo_wr_en), 32'd0);
        chk({tag, "_ready"}, 32'(req_ready), 32'd0);
        chk({tag, "_wr_data"}, 32'(fifo_wr_data), 32'd0);
    endtask

    initial begin
        ARESETN   = 1'b0;
        enable    = 1'b1;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        fifo_full = 1'b0;
        step();
        step();
        ARESETN = 1'b1;
        #1;
        chk_reset_outputs("rst");

        // single requester, three bytes
        set_req(2, 1'b1, 8'hA1, 1'b0);
        #1;
        chk("t1_idle_wr_en", 32'(fifo_wr_en), 32'd0);
        step();
        chk("t1_gid", 32'(grant_id), 32'd2);
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_ready", 32'(req_ready), 32'b0100);
        chk("t1_wr_en0", 32'(fifo_wr_en), 32'd1);
        chk("t1_data0", 32'(fifo_wr_data), 32'hA1);
        step();
        set_req(2, 1'b1, 8'hA2, 1'b0);
        #1;
        chk("t1_wr_en1", 32'(fifo_wr_en), 32'd1);
        chk("t1_data1", 32'(fifo_wr_data), 32'hA2);
        step();
        set_req(2, 1'b1, 8'hA3, 1'b1);
        #1;
        chk("t1_wr_en2", 32'(fifo_wr_en), 32'd1);
        chk("t1_data2", 32'(fifo_wr_data), 32'hA3);
        step();
        set_req(2, 1'b0, 8'h00, 1'b0);
        #1;
        chk("t1_pkt_done", 32'(pkt_done), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_wr_en_end", 32'(fifo_wr_en), 32'd0);
        step();
        chk("t1_pkt_done_pulse", 32'(pkt_done), 32'd0);

        // all four requesters, 2-byte packets, from reset
        ARESETN = 1'b0;
        step();
        ARESETN = 1'b1;
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b1, 8'(8'h30 + 2*i), 1'b0);
        #1;
        for (int p = 0; p < 5; p++) begin
            int g;
            g = p % NUM_REQ;
            step();
            chk("rr_gid", 32'(grant_id), 32'(g));
            chk("rr_busy", 32'(busy), 32'd1);
            chk("rr_ready", 32'(req_ready), 32'(1 << g));
            chk("rr_wr_en0", 32'(fifo_wr_en), 32'd1);
            chk("rr_data0", 32'(fifo_wr_data), 32'(8'h30 + 2*g));
            step();
            set_req(g, 1'b1, 8'(8'h31 + 2*g), 1'b1);
            #1;
            chk("rr_wr_en1", 32'(fifo_wr_en), 32'd1);
            chk("rr_data1", 32'(fifo_wr_data), 32'(8'h31 + 2*g));
            step();
            set_req(g, 1'b1, 8'(8'h30 + 2*g), 1'b0);
            #1;
            chk("rr_pkt_done", 32'(pkt_done), 32'd1);
            chk("rr_idle_busy", 32'(busy), 32'd0);
            chk("rr_idle_wr_en", 32'(fifo_wr_en), 32'd0);
        end
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 8'h00, 1'b0);
        #1;

        // fifo_full for 5 cycles mid-packet of req 1
        set_req(1, 1'b1, 8'h51, 1'b0);
        step();
        chk("ff_gid", 32'(grant_id), 32'd1);
        chk("ff_data0", 32'(fifo_wr_data), 32'h51);
        chk("ff_wr_en0", 32'(fifo_wr_en), 32'd1);
        step();
        set_req(1, 1'b1, 8'h52, 1'b0);
        fifo_full = 1'b1;
        #1;
        for (int c = 0; c < 5; c++) begin
            chk("ff_hold_wr_en", 32'(fifo_wr_en), 32'd0);
            chk("ff_hold_ready", 32'(req_ready), 32'd0);
            chk("ff_hold_gid", 32'(grant_id), 32'd1);
            chk("ff_hold_busy", 32'(busy), 32'd1);
            chk("ff_hold_data", 32'(fifo_wr_data), 32'h52);
            step();
        end
        fifo_full = 1'b0;
        #1;
        chk("ff_resume_wr_en", 32'(fifo_wr_en), 32'd1);
        chk("ff_resume_ready", 32'(req_ready), 32'b0010);
        chk("ff_resume_data", 32'(fifo_wr_data), 32'h52);
        step();
        set_req(1, 1'b1, 8'h53, 1'b1);
        #1;
        chk("ff_data2", 32'(fifo_wr_data), 32'h53);
        chk("ff_wr_en2", 32'(fifo_wr_en), 32'd1);
        chk("ff_no_early_end", 32'(err_len), 32'd0);
        step();
        set_req(1, 1'b0, 8'h00, 1'b0);
        #1;
        chk("ff_pkt_done", 32'(pkt_done), 32'd1);
        chk("ff_err_len", 32'(err_len), 32'd0);

        // req 0 streams 6 bytes, length limit 4
        set_req(0, 1'b1, 8'h60, 1'b0);
        step();
        chk("ml_gid", 32'(grant_id), 32'd0);
        for (int b = 0; b < 4; b++) begin
            chk("ml_wr_en", 32'(fifo_wr_en), 32'd1);
            chk("ml_data", 32'(fifo_wr_data), 32'(8'h60 + b));
            step();
            set_req(0, 1'b1, 8'(8'h61 + b), 1'b0);
            #1;
        end
        chk("ml_err_len", 32'(err_len), 32'd1);
        chk("ml_pkt_done", 32'(pkt_done), 32'd0);
        chk("ml_busy", 32'(busy), 32'd0);
        chk("ml_idle_wr_en", 32'(fifo_wr_en), 32'd0);
        step();
        chk("ml_err_pulse", 32'(err_len), 32'd0);
        chk("ml_regrant", 32'(grant_id), 32'd0);
        chk("ml_busy2", 32'(busy), 32'd1);
        chk("ml_data4", 32'(fifo_wr_data), 32'h64);
        chk("ml_wr_en4", 32'(fifo_wr_en), 32'd1);
        step();
        set_req(0, 1'b1, 8'h65, 1'b1);
        #1;
        chk("ml_data5", 32'(fifo_wr_data), 32'h65);
        step();
        set_req(0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("ml_pkt_done2", 32'(pkt_done), 32'd1);

        // last and length limit on the same beat
        set_req(2, 1'b1, 8'h70, 1'b0);
        step();
        chk("lw_gid", 32'(grant_id), 32'd2);
        for (int b = 0; b < 4; b++) begin
            chk("lw_data", 32'(fifo_wr_data), 32'(8'h70 + b));
            step();
            if (b < 3) set_req(2, 1'b1, 8'(8'h71 + b), (b == 2));
            else       set_req(2, 1'b0, 8'h00, 1'b0);
            #1;
        end
        chk("lw_pkt_done", 32'(pkt_done), 32'd1);
        chk("lw_err_len", 32'(err_len), 32'd0);

        // enable dropped after first byte of req 3 packet, req 0 waiting
        set_req(3, 1'b1, 8'h81, 1'b0);
        set_req(0, 1'b1, 8'h90, 1'b1);
        step();
        chk("en_gid", 32'(grant_id), 32'd3);
        chk("en_data0", 32'(fifo_wr_data), 32'h81);
        step();
        enable = 1'b0;
        set_req(3, 1'b1, 8'h82, 1'b0);
        #1;
        chk("en_wr_en1", 32'(fifo_wr_en), 32'd1);
        chk("en_data1", 32'(fifo_wr_data), 32'h82);
        step();
        set_req(3, 1'b1, 8'h83, 1'b1);
        #1;
        chk("en_data2", 32'(fifo_wr_data), 32'h83);
        step();
        set_req(3, 1'b0, 8'h00, 1'b0);
        #1;
        chk("en_pkt_done", 32'(pkt_done), 32'd1);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("en_hold_busy", 32'(busy), 32'd0);
            chk("en_hold_gid", 32'(grant_id), 32'd3);
            chk("en_hold_wr_en", 32'(fifo_wr_en), 32'd0);
        end
        enable = 1'b1;
        step();
        chk("en_regrant", 32'(grant_id), 32'd0);
        chk("en_busy", 32'(busy), 32'd1);
        chk("en_data_r0", 32'(fifo_wr_data), 32'h90);
        step();
        set_req(0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("en_pkt_done2", 32'(pkt_done), 32'd1);

        // reset mid-packet
        set_req(1, 1'b1, 8'hB1, 1'b0);
        step();
        chk("rm_gid", 32'(grant_id), 32'd1);
        step();
        set_req(1, 1'b1, 8'hB2, 1'b0);
        set_req(3, 1'b1, 8'hE1, 1'b1);
        ARESETN = 1'b0;
        step();
        ARESETN = 1'b1;
        #1;
        chk_reset_outputs("rm");
        step();
        chk("rm_regrant", 32'(grant_id), 32'd1);
        chk("rm_data", 32'(fifo_wr_data), 32'hB2);
        chk("rm_no_pulse", 32'({pkt_done, err_len}), 32'd0);
        set_req(1, 1'b1, 8'hB2, 1'b1);
        step();
        set_req(1, 1'b0, 8'h00, 1'b0);
        set_req(3, 1'b0, 8'h00, 1'b0);
        #1;
        chk("rm_pkt_done", 32'(pkt_done), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
